// File: rtl/contador_secuenciador.sv
// contador_secuenciador: sequences an external up-counter through a
// clear / count-to-limit run, with pause and abort, and watches the counter's
// reported value Q to flag any step it did not take as commanded.
module contador_secuenciador #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] limit,
   input  logic             hold,
   input  logic             abort,
   input  logic [WIDTH-1:0] q_in,
   output logic             en,
   output logic             clr,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_COUNT = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4,
      S_ABORT = 3'd5
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] lim_reg, lim_next;
   logic             err_reg, err_next;
   logic             start_accept;

   // Checker history: the command issued last cycle and the Q it applied to.
   logic             hist_valid_reg, hist_valid_next;
   logic             hist_en_reg, hist_clr_reg;
   logic [WIDTH-1:0] hist_q_reg;
   logic [WIDTH-1:0] hist_expect;
   logic             mismatch;

   assign state = state_reg;

   // State, captured limit, sticky error and checker history registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         lim_reg        <= '0;
         err_reg        <= 1'b0;
         hist_valid_reg <= 1'b0;
         hist_en_reg    <= 1'b0;
         hist_clr_reg   <= 1'b0;
         hist_q_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         lim_reg        <= lim_next;
         err_reg        <= err_next;
         hist_valid_reg <= hist_valid_next;
         hist_en_reg    <= en;
         hist_clr_reg   <= clr;
         hist_q_reg     <= q_in;
      end
   end

   // Next-state and counter command decode; abort outranks hold, hold outranks completion.
   always_comb begin
      state_next   = state_reg;
      lim_next     = lim_reg;
      en           = 1'b0;
      clr          = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      start_accept = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               start_accept = 1'b1;
               state_next   = S_CLEAR;
            end
         end
         S_CLEAR: begin
            en   = 1'b1;
            clr  = 1'b1;
            busy = 1'b1;
            state_next = abort ? S_ABORT : S_COUNT;
         end
         S_COUNT: begin
            busy = 1'b1;
            // Never step past the limit: the enable drops in the same cycle Q reaches it.
            en   = !hold && !abort && (q_in != lim_reg);
            if (abort)
               state_next = S_ABORT;
            else if (hold)
               state_next = S_PAUSE;
            else if (q_in == lim_reg)
               state_next = S_DONE;
         end
         S_PAUSE: begin
            busy = 1'b1;
            if (abort)
               state_next = S_ABORT;
            else if (!hold)
               state_next = S_COUNT;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               start_accept = 1'b1;
               state_next   = S_CLEAR;
            end else begin
               state_next   = S_IDLE;
            end
         end
         S_ABORT: begin
            en   = 1'b1;
            clr  = 1'b1;
            busy = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      if (start_accept)
         lim_next = limit;
   end

   // Counter checker: predict Q from last cycle's command and compare with what the counter reports.
   always_comb begin
      hist_expect = hist_q_reg;
      if (hist_en_reg && hist_clr_reg)
         hist_expect = '0;
      else if (hist_en_reg)
         hist_expect = hist_q_reg + WIDTH'(1);
      mismatch = hist_valid_reg && (q_in != hist_expect);
      // History only becomes trustworthy once this block has cleared the counter,
      // and stays so while the run (or its abort clear) is in progress.
      hist_valid_next = (state_reg == S_CLEAR) ||
                        (hist_valid_reg && ((state_reg == S_COUNT) ||
                                            (state_reg == S_PAUSE) ||
                                            (state_reg == S_ABORT)));
      err_next = start_accept ? 1'b0 : (err_reg | mismatch);
      // A mismatch is flagged in the very cycle the wrong Q is seen, then held.
      err = err_reg | mismatch;
   end

endmodule
